// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands (unsigned or
// two's-complement) are compared CHUNK bits per clock, most significant chunk
// first. The compare stops at the first chunk that differs. The result is a
// one-hot g/l/e triple that is registered and held until the next completion.
//
// Parameters:
//   WIDTH        operand width in bits (>= 2, divisible by CHUNK)
//   CHUNK        bits compared per clock (1 .. WIDTH)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, accepted only while idle
//   a, b         operands, sampled on the accepting edge only
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled with a/b)
//   busy         high while a compare is in progress
//   done         one-cycle pulse when g/l/e update
//   g, l, e      A > B, A < B, A == B (registered, held)
// -----------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             e
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int STEP_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NCHUNK - 1);
  // Flipping the sign bit maps two's-complement onto offset binary, so the
  // plain unsigned chunk compare orders signed values correctly.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [STEP_W-1:0] step;
  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;

  function automatic logic [CHUNK-1:0] top_chunk(input logic [WIDTH-1:0] v);
    return v[WIDTH-1 -: CHUNK];
  endfunction

  function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return is_signed ? (v ^ MSB_MASK) : v;
  endfunction

  // The captured operands are shifted left one chunk per step, so the chunk
  // under test is always the top CHUNK bits; this avoids a variable part-select.
  always_comb begin
    chunk_a = top_chunk(a_q);
    chunk_b = top_chunk(b_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
      e     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= to_offset(a, signed_mode);
            b_q   <= to_offset(b, signed_mode);
            step  <= '0;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end

        COMPARE: begin
          if (chunk_a != chunk_b) begin
            g     <= (chunk_a > chunk_b);
            l     <= (chunk_a < chunk_b);
            e     <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (step == LAST_STEP) begin
            g     <= 1'b0;
            l     <= 1'b0;
            e     <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            step <= step + STEP_W'(1);
            a_q  <= a_q << CHUNK;
            b_q  <= b_q << CHUNK;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//
// Directed-vector bench for seq_magnitude_comparator at WIDTH=16, CHUNK=2.
// Expected g/l/e and latencies are hand-computed from the operands: latency is
// 1 + index of the first differing 2-bit chunk (MSB chunk = index 0), or 8
// when the operands are equal.
// -----------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int CHUNK = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             g;
  logic             l;
  logic             e;

  int n_chk  = 0;
  int n_pass = 0;

  seq_magnitude_comparator #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .busy       (busy),
    .done       (done),
    .g          (g),
    .l          (l),
    .e          (e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Holds start high across one rising edge; the caller positions time so that
  // the DUT is idle at that edge. Returns 1 time unit after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic sm, input string tag);
    a           = ta;
    b           = tb;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
  endtask

  // Counts rising edges until done, bounded; checks latency and the result.
  task automatic wait_result(input string tag, input logic [2:0] exp_gle,
                             input int exp_lat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"},   32'(lat),  32'(exp_lat));
    check({tag, "_gle"},       32'({g, l, e}), 32'(exp_gle));
    check({tag, "_busy_low"},  32'(busy), 32'd0);
  endtask

  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb, input logic sm,
                         input logic [2:0] exp_gle, input int exp_lat);
    @(negedge clk);
    accept(ta, tb, sm, tag);
    wait_result(tag, exp_gle, exp_lat);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b1;
    a           = 16'h8000;
    b           = 16'h0000;
    signed_mode = 1'b0;

    // Reset held with start asserted: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_gle",  32'({g, l, e}), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    // Unsigned early exit: chunk0 10 vs 01.
    run_cmp("uns_early", 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1);
    @(posedge clk);
    #1;
    check("uns_early_done_pulse", 32'(done), 32'd0);

    // Signed early exit: -32768 < 32767.
    run_cmp("sgn_early", 16'h8000, 16'h7FFF, 1'b1, 3'b010, 1);
    // Signed -1 > -2, differing only in the LSB chunk.
    run_cmp("sgn_full",  16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 8);

    // Full-length compares.
    run_cmp("equal",     16'h1234, 16'h1234, 1'b0, 3'b001, 8);
    @(posedge clk);
    #1;
    check("equal_done_pulse", 32'(done), 32'd0);
    run_cmp("lsb_diff",  16'h0001, 16'h0000, 1'b0, 3'b100, 8);
    // First difference in bits [11:10] (chunk index 2).
    run_cmp("mid_diff",  16'h0400, 16'h0800, 1'b0, 3'b010, 3);

    // start pulsed while busy with operands that would give l in 1 cycle.
    @(negedge clk);
    accept(16'h0001, 16'h0000, 1'b0, "ignore");
    @(negedge clk);
    a     = 16'h0000;
    b     = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore_still_busy", 32'(busy), 32'd1);
    wait_result("ignore", 3'b100, 7);

    // Back-to-back: start presented in the done cycle is accepted.
    @(negedge clk);
    accept(16'h8000, 16'h7FFF, 1'b0, "b2b_first");
    wait_result("b2b_first", 3'b100, 1);
    accept(16'h0400, 16'h0800, 1'b0, "b2b_second");
    check("b2b_held_gle", 32'({g, l, e}), 32'b100);
    check("b2b_no_done",  32'(done), 32'd0);
    wait_result("b2b_second", 3'b010, 3);

    // Reset dropped at step 3 of an equal compare.
    @(negedge clk);
    accept(16'h1234, 16'h1234, 1'b0, "mid_rst");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_gle",  32'({g, l, e}), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp("after_rst", 16'h0001, 16'h0000, 1'b0, 3'b100, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
